// File: rtl/text_console_writer.sv
// text_console_writer
//   Write side of the VGA text-mode character buffer. Places incoming
//   character codes into the row-major character RAM, tracks the cursor,
//   interprets BS/LF/CR, scrolls by copying rows within the RAM and
//   clears the whole screen on request. Owns a single shared RAM port.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   char_i, char_valid_i  character stream from the bus-side register
//   char_ready_o          combinational: IDLE and no clear request
//   clear_i               full-screen clear request (sampled in IDLE)
//   busy_o                block is not IDLE
//   mem_we_o/addr_o/wdata_o/rdata_i  character RAM port (1-cycle read latency)
//   cursor_row_o/col_o/addr_o        current cursor position and RAM address
module text_console_writer #(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 60,
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        char_i,
    input  logic              char_valid_i,
    output logic              char_ready_o,
    input  logic              clear_i,
    output logic              busy_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    output logic [5:0]        cursor_row_o,
    output logic [6:0]        cursor_col_o,
    output logic [ADDR_W-1:0] cursor_addr_o
);

    localparam logic [ADDR_W-1:0] COLS_A        = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] ONE_A         = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_COPY     = ADDR_W'((ROWS - 1) * COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] LAST_CELL     = ADDR_W'(ROWS * COLS - 1);
    localparam logic [5:0]        LAST_ROW      = 6'(ROWS - 1);
    localparam logic [6:0]        LAST_COL      = 7'(COLS - 1);

    localparam logic [7:0] C_BS  = 8'h08;
    localparam logic [7:0] C_LF  = 8'h0A;
    localparam logic [7:0] C_CR  = 8'h0D;
    localparam logic [7:0] C_SP  = 8'h20;
    localparam logic [7:0] C_DEL = 8'h7F;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUT     = 3'd1,
        SCR_RD  = 3'd2,
        SCR_WR  = 3'd3,
        SCR_CLR = 3'd4,
        CLR     = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          char_q, char_d;
    logic                no_adv_q, no_adv_d;   // PUT issued by BS: do not advance
    logic [5:0]          row_q, row_d;
    logic [6:0]          col_q, col_d;
    logic [ADDR_W-1:0]   caddr_q, caddr_d;
    logic [ADDR_W-1:0]   base_q, base_d;       // address of column 0 of the cursor row
    logic [ADDR_W-1:0]   k_q, k_d;             // scroll / clear index

    assign char_ready_o  = (state_q == IDLE) && !clear_i;
    assign busy_o        = (state_q != IDLE);
    assign cursor_row_o  = row_q;
    assign cursor_col_o  = col_q;
    assign cursor_addr_o = caddr_q;

    // State and cursor registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            char_q   <= '0;
            no_adv_q <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            caddr_q  <= '0;
            base_q   <= '0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            char_q   <= char_d;
            no_adv_q <= no_adv_d;
            row_q    <= row_d;
            col_q    <= col_d;
            caddr_q  <= caddr_d;
            base_q   <= base_d;
            k_q      <= k_d;
        end
    end

    // Next-state, cursor update and RAM port drive
    always_comb begin
        state_d     = state_q;
        char_d      = char_q;
        no_adv_d    = no_adv_q;
        row_d       = row_q;
        col_d       = col_q;
        caddr_d     = caddr_q;
        base_d      = base_q;
        k_d         = k_q;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        case (state_q)
            IDLE: begin
                if (clear_i) begin
                    state_d = CLR;
                    row_d   = '0;
                    col_d   = '0;
                    caddr_d = '0;
                    base_d  = '0;
                    k_d     = '0;
                end else if (char_valid_i) begin
                    if (char_i == C_LF) begin
                        col_d   = '0;
                        caddr_d = base_q;
                        if (row_q == LAST_ROW) begin
                            state_d = SCR_RD;
                            k_d     = '0;
                        end else begin
                            row_d   = row_q + 6'd1;
                            base_d  = base_q + COLS_A;
                            caddr_d = base_q + COLS_A;
                        end
                    end else if (char_i == C_CR) begin
                        col_d   = '0;
                        caddr_d = base_q;
                    end else if (char_i == C_BS) begin
                        if (col_q != 7'd0) begin
                            col_d    = col_q - 7'd1;
                            caddr_d  = caddr_q - ONE_A;
                            char_d   = C_SP;
                            no_adv_d = 1'b1;
                            state_d  = PUT;
                        end
                    end else if ((char_i >= C_SP) && (char_i != C_DEL)) begin
                        char_d   = char_i;
                        no_adv_d = 1'b0;
                        state_d  = PUT;
                    end
                end
            end

            PUT: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = caddr_q;
                mem_wdata_o = char_q;
                state_d     = IDLE;
                if (!no_adv_q) begin
                    if (col_q != LAST_COL) begin
                        col_d   = col_q + 7'd1;
                        caddr_d = caddr_q + ONE_A;
                    end else if (row_q != LAST_ROW) begin
                        col_d   = '0;
                        row_d   = row_q + 6'd1;
                        base_d  = base_q + COLS_A;
                        caddr_d = base_q + COLS_A;
                    end else begin
                        // Wrapped off the bottom row: cursor to start of last row, then scroll
                        col_d   = '0;
                        caddr_d = base_q;
                        k_d     = '0;
                        state_d = SCR_RD;
                    end
                end
            end

            SCR_RD: begin
                mem_addr_o = k_q + COLS_A;
                state_d    = SCR_WR;
            end

            SCR_WR: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = k_q;
                mem_wdata_o = mem_rdata_i;
                if (k_q == LAST_COPY) begin
                    k_d     = LAST_ROW_BASE;
                    state_d = SCR_CLR;
                end else begin
                    k_d     = k_q + ONE_A;
                    state_d = SCR_RD;
                end
            end

            SCR_CLR, CLR: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = k_q;
                mem_wdata_o = C_SP;
                if (k_q == LAST_CELL) begin
                    state_d = IDLE;
                end else begin
                    k_d = k_q + ONE_A;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: a table of directed
// characters with literal expectations, hand sequences for cursor,
// scroll, clear and reset corners, and a randomized stream checked
// against a screen/cursor reference model.
module tb_text_console_writer;

    localparam int COLS       = 80;
    localparam int ROWS       = 60;
    localparam int ADDR_W     = 13;
    localparam int CELLS      = COLS * ROWS;
    localparam int SCROLL_CYC = 2 * (ROWS - 1) * COLS + COLS;
    localparam int TIMEOUT    = 20000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        char_in = 8'h00;
    logic              char_valid = 1'b0;
    logic              char_ready;
    logic              clear = 1'b0;
    logic              busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic [5:0]        cur_row;
    logic [6:0]        cur_col;
    logic [ADDR_W-1:0] cur_addr;

    int checks = 0;
    int errors = 0;

    text_console_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .char_i       (char_in),
        .char_valid_i (char_valid),
        .char_ready_o (char_ready),
        .clear_i      (clear),
        .busy_o       (busy),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .cursor_row_o (cur_row),
        .cursor_col_o (cur_col),
        .cursor_addr_o(cur_addr)
    );

    always #5 clk = ~clk;

    // Character RAM with registered read; also logs writes
    logic [7:0]        ram [0:CELLS-1];
    int                wr_cnt = 0;
    logic [ADDR_W-1:0] last_waddr = '0;
    logic [7:0]        last_wdata = '0;

    always @(posedge clk) begin
        if (int'(mem_addr) < CELLS) mem_rdata <= ram[mem_addr];
        if (mem_we) begin
            if (int'(mem_addr) < CELLS) begin
                ram[mem_addr] = mem_wdata;
            end else begin
                errors++;
                $display("FAIL addr_range: write address %0d, limit %0d", mem_addr, CELLS - 1);
            end
            wr_cnt++;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
        end
    end

    // Reference model: screen as rows of characters plus a cursor
    logic [7:0] mscr [0:ROWS-1][0:COLS-1];
    int mrow = 0, mcol = 0, mscrolls = 0;

    function automatic void m_scroll();
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++) mscr[r][c] = mscr[r+1][c];
        for (int c = 0; c < COLS; c++) mscr[ROWS-1][c] = 8'h20;
        mscrolls++;
    endfunction

    function automatic bit m_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c != 8'h7F);
    endfunction

    // Applies one code to the model; returns the expected not-ready cycle count
    function automatic int m_put(input logic [7:0] c);
        int lat = 0;
        if (c == 8'h0A) begin
            mcol = 0;
            if (mrow == ROWS - 1) begin m_scroll(); lat = SCROLL_CYC; end
            else mrow++;
        end else if (c == 8'h0D) begin
            mcol = 0;
        end else if (c == 8'h08) begin
            if (mcol > 0) begin mcol--; mscr[mrow][mcol] = 8'h20; lat = 1; end
        end else if (m_printable(c)) begin
            mscr[mrow][mcol] = c;
            lat = 1;
            if (mcol < COLS - 1) mcol++;
            else begin
                mcol = 0;
                if (mrow < ROWS - 1) mrow++;
                else begin m_scroll(); lat += SCROLL_CYC; end
            end
        end
        return lat;
    endfunction

    function automatic bit m_would_scroll(input logic [7:0] c);
        if (mrow != ROWS - 1) return 1'b0;
        if (c == 8'h0A) return 1'b1;
        return m_printable(c) && (mcol == COLS - 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    // Waits for ready, presents one character for one cycle, then counts
    // cycles until ready returns (and how many of them had busy high)
    task automatic send_char(input logic [7:0] c, output int nlow, output int nbusy);
        int g = 0;
        while (!char_ready && g < TIMEOUT) begin @(negedge clk); g++; end
        wr_cnt = 0;
        char_in = c;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
        nlow = 0;
        nbusy = 0;
        while (!char_ready && nlow < TIMEOUT) begin
            if (busy) nbusy++;
            nlow++;
            @(negedge clk);
        end
    endtask

    task automatic send_chk(input logic [7:0] c, input string tag);
        int want_lat, nlow, nb;
        want_lat = m_put(c);
        send_char(c, nlow, nb);
        chk({tag, "_lat"}, nlow, want_lat);
        chk({tag, "_busy"}, nb, want_lat);
        chk({tag, "_row"}, 32'(cur_row), mrow);
        chk({tag, "_col"}, 32'(cur_col), mcol);
        chk({tag, "_addr"}, 32'(cur_addr), mrow * COLS + mcol);
    endtask

    task automatic chk_screen(input string name);
        int bad = 0;
        for (int a = 0; a < CELLS; a++)
            if (ram[a] !== mscr[a / COLS][a % COLS]) bad++;
        chk(name, bad, 0);
    endtask

    typedef struct {
        logic [7:0] c;
        int lat;
        int nwr;
        int waddr;
        int wdata;
        int row;
        int col;
        int addr;
    } vec_t;

    vec_t       tbl [13];
    logic [7:0] snap [0:CELLS-1];

    initial begin
        int nlow, nb, cnt, v;
        logic [7:0] c;

        tbl[0]  = '{8'h41, 1, 1,  0, 8'h41, 0, 1,  1};
        tbl[1]  = '{8'h0D, 0, 0,  0, 0,     0, 0,  0};
        tbl[2]  = '{8'h0A, 0, 0,  0, 0,     1, 0, 80};
        tbl[3]  = '{8'h5A, 1, 1, 80, 8'h5A, 1, 1, 81};
        tbl[4]  = '{8'h08, 1, 1, 80, 8'h20, 1, 0, 80};
        tbl[5]  = '{8'h08, 0, 0,  0, 0,     1, 0, 80};
        tbl[6]  = '{8'h07, 0, 0,  0, 0,     1, 0, 80};
        tbl[7]  = '{8'h7F, 0, 0,  0, 0,     1, 0, 80};
        tbl[8]  = '{8'h80, 1, 1, 80, 8'h80, 1, 1, 81};
        tbl[9]  = '{8'hFF, 1, 1, 81, 8'hFF, 1, 2, 82};
        tbl[10] = '{8'h1F, 0, 0,  0, 0,     1, 2, 82};
        tbl[11] = '{8'h20, 1, 1, 82, 8'h20, 1, 3, 83};
        tbl[12] = '{8'h7E, 1, 1, 83, 8'h7E, 1, 4, 84};

        for (int a = 0; a < CELLS; a++) begin
            ram[a] = 8'(a % 256);
            mscr[a / COLS][a % COLS] = 8'(a % 256);
        end

        // Reset values
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(char_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_maddr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_row", 32'(cur_row), 0);
        chk("rst_col", 32'(cur_col), 0);
        chk("rst_caddr", 32'(cur_addr), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 13; i++) begin
            void'(m_put(tbl[i].c));
            send_char(tbl[i].c, nlow, nb);
            chk($sformatf("tbl%0d_lat", i), nlow, tbl[i].lat);
            chk($sformatf("tbl%0d_nwr", i), wr_cnt, tbl[i].nwr);
            if (tbl[i].nwr != 0) begin
                chk($sformatf("tbl%0d_waddr", i), 32'(last_waddr), tbl[i].waddr);
                chk($sformatf("tbl%0d_wdata", i), 32'(last_wdata), tbl[i].wdata);
            end
            chk($sformatf("tbl%0d_row", i), 32'(cur_row), tbl[i].row);
            chk($sformatf("tbl%0d_col", i), 32'(cur_col), tbl[i].col);
            chk($sformatf("tbl%0d_addr", i), 32'(cur_addr), tbl[i].addr);
        end

        // Cursor at row 5, col 10: CR, LF, BS corners
        for (int i = 0; i < 4; i++) send_chk(8'h0A, "lf_down");
        for (int i = 0; i < 10; i++) send_chk(8'h78, "fill_x");
        chk("pos_5_10", 32'(cur_addr), 410);
        send_chk(8'h0D, "cr");
        chk("cr_addr", 32'(cur_addr), 400);
        send_chk(8'h0A, "lf");
        chk("lf_row", 32'(cur_row), 6);
        chk("lf_addr", 32'(cur_addr), 480);
        for (int i = 0; i < 3; i++) send_chk(8'h79, "fill_y");
        send_chk(8'h08, "bs");
        chk("bs_nwr", wr_cnt, 1);
        chk("bs_waddr", 32'(last_waddr), 482);
        chk("bs_wdata", 32'(last_wdata), 8'h20);
        chk("bs_col", 32'(cur_col), 2);
        send_chk(8'h0D, "cr2");
        send_chk(8'h08, "bs_col0");
        chk("bs_col0_nwr", wr_cnt, 0);

        // A full line wraps to the next row
        for (int i = 0; i < COLS; i++) send_chk(8'(8'h61 + i % 26), "line");
        chk("wrap_row", 32'(cur_row), 7);
        chk("wrap_col", 32'(cur_col), 0);
        chk("wrap_addr", 32'(cur_addr), 560);
        send_chk(8'h42, "B");
        chk("B_waddr", 32'(last_waddr), 560);
        chk("B_wdata", 32'(last_wdata), 8'h42);
        chk_screen("screen_a");

        // LF on the last row scrolls
        for (int i = 0; i < 52; i++) send_chk(8'h0A, "lf_bottom");
        chk("bottom_row", 32'(cur_row), 59);
        for (int a = 0; a < CELLS; a++) snap[a] = ram[a];
        send_chk(8'h0A, "scroll_lf");
        chk("scr_first", 32'(ram[0]), 32'(snap[80]));
        chk("scr_last_copy", 32'(ram[4719]), 32'(snap[4799]));
        cnt = 0;
        for (int a = 4720; a < CELLS; a++) if (ram[a] === 8'h20) cnt++;
        chk("scr_blank_row", cnt, 80);
        chk("scr_row", 32'(cur_row), 59);
        chk("scr_col", 32'(cur_col), 0);
        chk("scr_addr", 32'(cur_addr), 4720);
        chk_screen("screen_b");

        // Randomized stream on the bottom row, scroll count bounded
        for (int i = 0; i < 100; i++) begin
            v = $urandom_range(0, 15);
            case (v)
                0: c = 8'h0A;
                1: c = 8'h0D;
                2, 3: c = 8'h08;
                4: begin
                    v = $urandom_range(0, 32);
                    c = (v == 32) ? 8'h7F : 8'(v);
                end
                default: begin
                    c = 8'($urandom_range(32, 255));
                    if (c == 8'h7F) c = 8'h41;
                end
            endcase
            if (m_would_scroll(c) && mscrolls >= 4) c = 8'h0D;
            send_chk(c, "rnd");
        end
        chk_screen("screen_rnd");

        // Wrap off the bottom-right cell scrolls after the write
        send_chk(8'h0D, "cr3");
        for (int i = 0; i < COLS; i++) send_chk(8'(8'h30 + i % 10), "last_line");
        chk("wrapscr_row", 32'(cur_row), 59);
        chk("wrapscr_addr", 32'(cur_addr), 4720);
        chk_screen("screen_c");

        // Clear with a simultaneous character
        clear = 1'b1;
        char_in = 8'h51;
        char_valid = 1'b1;
        #1;
        chk("clr_ready_low", 32'(char_ready), 0);
        wr_cnt = 0;
        @(negedge clk);
        clear = 1'b0;
        char_valid = 1'b0;
        cnt = 0;
        while (busy && cnt < TIMEOUT) begin cnt++; @(negedge clk); end
        chk("clr_cycles", cnt, CELLS);
        chk("clr_writes", wr_cnt, CELLS);
        cnt = 0;
        for (int a = 0; a < CELLS; a++) if (ram[a] !== 8'h20) cnt++;
        chk("clr_nonblank", cnt, 0);
        chk("clr_row", 32'(cur_row), 0);
        chk("clr_col", 32'(cur_col), 0);
        chk("clr_addr", 32'(cur_addr), 0);
        chk("clr_ready", 32'(char_ready), 1);
        for (int r = 0; r < ROWS; r++)
            for (int cc = 0; cc < COLS; cc++) mscr[r][cc] = 8'h20;
        mrow = 0;
        mcol = 0;

        // Reset in the middle of a scroll
        for (int i = 0; i < ROWS - 1; i++) send_chk(8'h0A, "lf_pre_rst");
        char_in = 8'h0A;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
        repeat (3000) @(negedge clk);
        chk("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("arst_ready", 32'(char_ready), 1);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_we", 32'(mem_we), 0);
        chk("arst_maddr", 32'(mem_addr), 0);
        chk("arst_wdata", 32'(mem_wdata), 0);
        chk("arst_row", 32'(cur_row), 0);
        chk("arst_col", 32'(cur_col), 0);
        chk("arst_caddr", 32'(cur_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_char(8'h43, nlow, nb);
        chk("post_rst_nwr", wr_cnt, 1);
        chk("post_rst_waddr", 32'(last_waddr), 0);
        chk("post_rst_wdata", 32'(last_wdata), 8'h43);
        chk("post_rst_col", 32'(cur_col), 1);
        chk("post_rst_addr", 32'(cur_addr), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
